mlp_frame_driver: RTL

Sequential front/back end for the combinational printed-MLP classifier. It receives input features one beat at a time over a valid/ready stream and packs them into the flat feature vector that drives the classifier input. It holds that vector stable for a fixed settle window, then samples the classifier's class index. The class is returned on a valid/ready result stream with a frame-length error flag and a running frame count.

---
 rtl/mlp_frame_driver.sv | 83 ++++++++
 1 files changed

// File: rtl/mlp_frame_driver.sv
// mlp_frame_driver: packs a valid/ready feature stream into the classifier input vector,
// waits a settle window, then returns the sampled class with an error flag and frame count.
module mlp_frame_driver #(
    parameter int N_FEAT = 4,
    parameter int FEAT_W = 4,
    parameter int CLS_W  = 2,
    parameter int SETTLE = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [FEAT_W-1:0]        s_data,
    input  logic                     s_last,
    output logic [N_FEAT*FEAT_W-1:0] mlp_inp,
    input  logic [CLS_W-1:0]         mlp_out,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [CLS_W-1:0]         m_class,
    output logic                     m_err,
    output logic [7:0]               m_count
);
    localparam int IW = $clog2(N_FEAT);
    localparam int CW = $clog2(SETTLE + 1);

    typedef enum logic [1:0] {ST_COLLECT, ST_DRAIN, ST_SETTLE, ST_OUTPUT} state_t;

    state_t          state, state_n;
    logic [IW-1:0]   idx;
    logic [CW-1:0]   cnt;
    logic            err_pending;
    logic            acc, last_slot, settle_done;

    assign s_ready     = state == ST_COLLECT || state == ST_DRAIN;
    assign acc         = s_valid && s_ready;
    assign last_slot   = idx == IW'(N_FEAT - 1);
    assign settle_done = cnt == CW'(SETTLE - 1);

    always_ff @(posedge clk) begin
        if (rst) state <= ST_COLLECT;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        state_n = state == ST_COLLECT ? (acc && s_last ? ST_SETTLE : acc && last_slot ? ST_DRAIN : ST_COLLECT)
                : state == ST_DRAIN   ? (acc && s_last ? ST_SETTLE : ST_DRAIN)
                : state == ST_SETTLE  ? (settle_done ? ST_OUTPUT : ST_SETTLE)
                :                       (m_ready ? ST_COLLECT : ST_OUTPUT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx         <= '0;
            cnt         <= '0;
            err_pending <= 1'b0;
            mlp_inp     <= '0;
            m_valid     <= 1'b0;
            m_class     <= '0;
            m_err       <= 1'b0;
            m_count     <= '0;
        end else begin
            cnt <= state == ST_SETTLE ? cnt + 1'b1 : '0;
            if (state == ST_COLLECT && acc) begin
                // the first beat also clears stale slots so short frames read as zero-padded
                if (idx == '0) mlp_inp <= {{(N_FEAT-1)*FEAT_W{1'b0}}, s_data};
                else           mlp_inp[idx*FEAT_W +: FEAT_W] <= s_data;
                idx         <= idx + 1'b1;
                err_pending <= !last_slot || !s_last;
            end
            if (state == ST_SETTLE && settle_done) begin
                m_class <= mlp_out;
                m_err   <= err_pending;
                m_count <= m_count + 8'd1;
                m_valid <= 1'b1;
            end
            if (state == ST_OUTPUT && m_ready) begin
                m_valid <= 1'b0;
                idx     <= '0;
            end
        end
    end
endmodule
